// File: rtl/irq_timer.sv
// Prescaled down-counting timer with bus-mapped registers.
// Emits a one-clock irq pulse on expiry, one-shot or periodic.
module irq_timer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] data_write,
   output logic [15:0] data_read,
   input  logic [7:0]  addr,
   input  logic        uds,
   input  logic        lds,
   input  logic        rw,
   input  logic        as,
   output logic        ack,
   output logic        irq
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      st_q, st_d;
   logic        en_q, en_d;
   logic        per_q, per_d;
   logic        ien_q, ien_d;
   logic        exp_q, exp_d;
   logic [15:0] psc_q, psc_d;
   logic [15:0] rld_q, rld_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] pre_q, pre_d;
   logic        irq_q, irq_d;
   logic        ack_q, ack_d;
   logic [15:0] rd_q, rd_d;

   logic [6:0]  widx;
   logic        mapped;
   logic [4:0]  wsel;
   logic [15:0] bmask;
   logic [15:0] rval;
   logic        ctrl_wr;
   logic        start;
   logic        stop;
   logic        tick;
   logic        expire;
   logic        unused_a0;

   assign widx      = addr[7:1];
   assign unused_a0 = addr[0];
   assign mapped    = (widx <= 7'd4);
   assign bmask     = {{8{uds}}, {8{lds}}};

   always_comb begin
      for (int i = 0; i < 5; i++)
         wsel[i] = as & ~rw & (widx == 7'(i));
   end

   function automatic logic [15:0] merge(input logic [15:0] old);
      return (old & ~bmask) | (data_write & bmask);
   endfunction

   assign ctrl_wr = wsel[0] & lds;
   assign stop    = ctrl_wr & ~data_write[0];

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) st_q <= IDLE;
      else          st_q <= st_d;
   end

   // Next-state logic
   always_comb begin
      st_d = st_q;
      unique case (st_q)
         IDLE, HALT: if (start) st_d = RUN;
         RUN: begin
            if (expire && !per_q) st_d = HALT;
            else if (stop)        st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   // FSM outputs: counting only happens in RUN
   always_comb begin
      start  = 1'b0;
      tick   = 1'b0;
      expire = 1'b0;
      unique case (st_q)
         IDLE, HALT: start = ctrl_wr & data_write[0];
         RUN: begin
            tick   = (pre_q == psc_q);
            expire = tick & (cnt_q == 16'd0);
         end
         default: ;
      endcase
   end

   always_comb begin
      en_d  = en_q;
      per_d = per_q;
      ien_d = ien_q;
      psc_d = psc_q;
      rld_d = rld_q;
      if (ctrl_wr) begin
         en_d  = data_write[0];
         per_d = data_write[1];
         ien_d = data_write[2];
      end
      if (wsel[2]) psc_d = merge(psc_q);
      if (wsel[3]) rld_d = merge(rld_q);
      if (expire && !per_q) en_d = 1'b0;

      // A same-cycle expiry beats the write-1-clear
      exp_d = exp_q;
      if (wsel[1] && lds && data_write[0]) exp_d = 1'b0;
      if (expire) exp_d = 1'b1;

      pre_d = pre_q;
      cnt_d = cnt_q;
      if (st_q == RUN) begin
         pre_d = tick ? 16'd0 : pre_q + 16'd1;
         if (tick) begin
            if (expire) cnt_d = per_q ? rld_q : cnt_q;
            else        cnt_d = cnt_q - 16'd1;
         end
      end else if (start) begin
         cnt_d = rld_d;
         pre_d = 16'd0;
      end

      irq_d = expire & ien_q;
      ack_d = as & mapped;
      rd_d  = (as && rw) ? (rval & bmask) : 16'd0;
   end

   always_comb begin
      rval = 16'd0;
      case (widx)
         7'd0:    rval = {13'd0, ien_q, per_q, en_q};
         7'd1:    rval = {15'd0, exp_q};
         7'd2:    rval = psc_q;
         7'd3:    rval = rld_q;
         7'd4:    rval = cnt_q;
         default: rval = 16'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         en_q  <= 1'b0;
         per_q <= 1'b0;
         ien_q <= 1'b0;
         exp_q <= 1'b0;
         psc_q <= 16'd0;
         rld_q <= 16'd0;
         cnt_q <= 16'd0;
         pre_q <= 16'd0;
         irq_q <= 1'b0;
         ack_q <= 1'b0;
         rd_q  <= 16'd0;
      end else begin
         en_q  <= en_d;
         per_q <= per_d;
         ien_q <= ien_d;
         exp_q <= exp_d;
         psc_q <= psc_d;
         rld_q <= rld_d;
         cnt_q <= cnt_d;
         pre_q <= pre_d;
         irq_q <= irq_d;
         ack_q <= ack_d;
         rd_q  <= rd_d;
      end
   end

   assign data_read = rd_q;
   assign ack       = ack_q;
   assign irq       = irq_q;
endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer; read data checked through a
// queue of expected values popped when the DUT returns data.
module tb_irq_timer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] data_write = 16'd0;
   logic [15:0] data_read;
   logic [7:0]  addr = 8'd0;
   logic        uds = 1'b0;
   logic        lds = 1'b0;
   logic        rw = 1'b1;
   logic        as = 1'b0;
   logic        ack;
   logic        irq;

   int errors = 0;
   int checks = 0;
   int irq_n = 0;
   int base;
   logic [15:0] sb[$];

   irq_timer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_write (data_write),
      .data_read  (data_read),
      .addr       (addr),
      .uds        (uds),
      .lds        (lds),
      .rw         (rw),
      .as         (as),
      .ack        (ack),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (irq === 1'b1) irq_n++;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rst();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d,
                     input logic u, input logic l);
      addr = a; data_write = d; uds = u; lds = l; rw = 1'b0; as = 1'b1;
      cyc();
      as = 1'b0; rw = 1'b1;
      chk("wr_ack", {15'd0, ack}, 16'd1);
   endtask

   task automatic rd(input string tag, input logic [7:0] a,
                     input logic u, input logic l,
                     input logic [15:0] e, input logic ak);
      addr = a; uds = u; lds = l; rw = 1'b1; as = 1'b1;
      sb.push_back(e);
      cyc();
      as = 1'b0;
      chk({tag, "_ack"}, {15'd0, ack}, {15'd0, ak});
      chk(tag, data_read, sb.pop_front());
   endtask

   initial begin
      // Reset state
      rst();
      chk("rst_ack", {15'd0, ack}, 16'd0);
      chk("rst_irq", {15'd0, irq}, 16'd0);
      chk("rst_rd", data_read, 16'd0);
      for (int r = 0; r < 5; r++)
         rd("rst_reg", 8'(2 * r), 1'b1, 1'b1, 16'd0, 1'b1);

      // Byte-lane write and read
      wr(8'h06, 16'hAB55, 1'b1, 1'b0);
      rd("rld_both", 8'h06, 1'b1, 1'b1, 16'hAB00, 1'b1);
      rd("rld_lds", 8'h06, 1'b0, 1'b1, 16'h0000, 1'b1);
      rd("unmapped", 8'h20, 1'b1, 1'b1, 16'h0000, 1'b0);
      wr(8'h08, 16'h1234, 1'b1, 1'b1);
      rd("count_ro", 8'h08, 1'b1, 1'b1, 16'h0000, 1'b1);

      // Periodic, PRESCALE=3 RELOAD=4: 20-clk period
      rst();
      wr(8'h04, 16'd3, 1'b1, 1'b1);
      wr(8'h06, 16'd4, 1'b1, 1'b1);
      wr(8'h00, 16'h0007, 1'b1, 1'b1);
      for (int k = 0; k < 40; k++) begin
         chk("per_irq", {15'd0, irq},
             {15'd0, (k > 0 && k % 20 == 0)});
         rd("per_cnt", 8'h08, 1'b1, 1'b1,
            16'(4 - ((k % 20) / 4)), 1'b1);
      end
      rd("per_exp", 8'h02, 1'b1, 1'b1, 16'd1, 1'b1);

      // One-shot, RELOAD=2
      rst();
      wr(8'h06, 16'd2, 1'b1, 1'b1);
      wr(8'h00, 16'h0005, 1'b1, 1'b1);
      base = irq_n;
      for (int k = 0; k < 104; k++) begin
         if (k == 3) chk("os_irq", {15'd0, irq}, 16'd1);
         cyc();
      end
      chk("os_pulses", 16'(irq_n - base), 16'd1);
      rd("os_ctrl", 8'h00, 1'b1, 1'b1, 16'h0004, 1'b1);
      rd("os_exp", 8'h02, 1'b1, 1'b1, 16'd1, 1'b1);

      // Clear on the exact expiry edge: set wins
      rst();
      wr(8'h06, 16'd2, 1'b1, 1'b1);
      wr(8'h00, 16'h0005, 1'b1, 1'b1);
      cyc();
      cyc();
      wr(8'h02, 16'h0001, 1'b1, 1'b1);
      chk("w1c_irq", {15'd0, irq}, 16'd1);
      rd("w1c_same", 8'h02, 1'b1, 1'b1, 16'd1, 1'b1);
      wr(8'h02, 16'h0001, 1'b1, 1'b1);
      rd("w1c_after", 8'h02, 1'b1, 1'b1, 16'd0, 1'b1);

      // Clear one cycle after expiry
      rst();
      wr(8'h06, 16'd2, 1'b1, 1'b1);
      wr(8'h00, 16'h0005, 1'b1, 1'b1);
      cyc();
      cyc();
      cyc();
      chk("w1c2_irq", {15'd0, irq}, 16'd1);
      wr(8'h02, 16'h0001, 1'b1, 1'b1);
      rd("w1c_late", 8'h02, 1'b1, 1'b1, 16'd0, 1'b1);

      // Reset two clocks before expiry, with a bus write during reset
      rst();
      wr(8'h06, 16'd4, 1'b1, 1'b1);
      wr(8'h00, 16'h0005, 1'b1, 1'b1);
      base = irq_n;
      cyc();
      cyc();
      reset_n = 1'b0;
      addr = 8'h00; data_write = 16'h0007; uds = 1'b1; lds = 1'b1;
      rw = 1'b0; as = 1'b1;
      cyc();
      as = 1'b0; rw = 1'b1; reset_n = 1'b1;
      chk("mrst_ack", {15'd0, ack}, 16'd0);
      for (int k = 0; k < 10; k++) cyc();
      chk("mrst_noirq", 16'(irq_n - base), 16'd0);
      for (int r = 0; r < 5; r++)
         rd("mrst_reg", 8'(2 * r), 1'b1, 1'b1, 16'd0, 1'b1);

      // IRQEN off, then enabled mid-run without restart
      rst();
      wr(8'h06, 16'd2, 1'b1, 1'b1);
      wr(8'h00, 16'h0003, 1'b1, 1'b1);
      base = irq_n;
      for (int k = 0; k < 4; k++) cyc();
      rd("noien_exp", 8'h02, 1'b1, 1'b1, 16'd1, 1'b1);
      cyc();
      chk("noien_irq", 16'(irq_n - base), 16'd0);
      wr(8'h00, 16'h0007, 1'b1, 1'b1);
      for (int k = 7; k < 11; k++) begin
         chk("ien_irq", {15'd0, irq}, {15'd0, (k == 9)});
         cyc();
      end
      chk("ien_pulses", 16'(irq_n - base), 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
